// File: rtl/fairy_inst_prefetch.sv
// Instruction prefetch: sequential SRAM word reads queued as {pc, inst, unaligned} in a DEPTH-entry FIFO, flushed on redirect.
// rrdy->valid_o is 1 cycle (0 with FAIRY_PREFETCH_BYPASS_EN defined); requests stop while FIFO plus the outstanding slot is full.
module fairy_inst_prefetch #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter int          DEPTH    = 4
) (
  input  logic        aclk,
  input  logic        areset_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        pop_i,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        unaligned_addr_o,
  output logic [3:0]  inst_sram_cen_o,
  output logic        inst_sram_wr_o,
  output logic [31:0] inst_sram_addr_o,
  input  logic        inst_sram_ack_i,
  input  logic        inst_sram_rrdy_i,
  input  logic [31:0] inst_sram_rdata_i
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [2:0] S_REQ   = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_IDLE  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]    r_state, w_state_nxt;
  logic [31:0]   r_pc, r_req_pc;
  logic [31:0]   r_mem_pc   [DEPTH];
  logic [31:0]   r_mem_inst [DEPTH];
  logic          r_mem_unal [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count, w_count_nxt;

  logic        w_aligned, w_req, w_ack, w_resp, w_marker, w_byp;
  logic        w_push, w_pop, w_space, w_inflight, w_head_vld;
  logic [31:0] w_resp_pc;

  assign w_aligned  = (r_pc[1:0] == 2'b00);
  assign w_req      = areset_n && (r_state == S_REQ) && w_aligned;
  assign w_ack      = w_req && inst_sram_ack_i;
  assign w_resp     = inst_sram_rrdy_i && (w_ack || (r_state == S_WAIT));
  assign w_resp_pc  = (r_state == S_WAIT) ? r_req_pc : r_pc;
  assign w_marker   = (r_state == S_REQ) && !w_aligned && (r_count != FULL);
  assign w_head_vld = (r_count != '0);

  assign w_push      = (w_resp || w_marker) && !redirect_i && !(w_byp && pop_i);
  assign w_pop       = pop_i && w_head_vld && !redirect_i;
  assign w_count_nxt = redirect_i ? '0 : (r_count + (AW+1)'(w_push) - (AW+1)'(w_pop));
  assign w_space     = (w_count_nxt < FULL);
  // A request accepted but not yet answered must be drained after a flush.
  assign w_inflight  = !inst_sram_rrdy_i && (w_ack || (r_state == S_WAIT) || (r_state == S_DRAIN));

  assign inst_sram_cen_o  = w_req ? 4'b0000 : 4'b1111;
  assign inst_sram_addr_o = r_pc;
  assign inst_sram_wr_o   = 1'b0;

`ifdef FAIRY_PREFETCH_BYPASS_EN
  assign w_byp            = (r_count == '0) && w_resp && !redirect_i;
  assign valid_o          = w_head_vld || w_byp;
  assign inst_o           = w_head_vld ? r_mem_inst[r_rd_ptr] : (w_byp ? inst_sram_rdata_i : 32'h0);
  assign pc_o             = w_head_vld ? r_mem_pc[r_rd_ptr] : (w_byp ? w_resp_pc : 32'h0);
  assign unaligned_addr_o = w_head_vld && r_mem_unal[r_rd_ptr];
`else
  assign w_byp            = 1'b0;
  assign valid_o          = w_head_vld;
  assign inst_o           = w_head_vld ? r_mem_inst[r_rd_ptr] : 32'h0;
  assign pc_o             = w_head_vld ? r_mem_pc[r_rd_ptr] : 32'h0;
  assign unaligned_addr_o = w_head_vld && r_mem_unal[r_rd_ptr];
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ: begin
        if (!w_aligned) begin
          if (w_marker) w_state_nxt = S_STOP;
        end else if (inst_sram_ack_i) begin
          if (!inst_sram_rrdy_i) w_state_nxt = S_WAIT;
          else                   w_state_nxt = w_space ? S_REQ : S_IDLE;
        end
      end
      S_WAIT:  if (inst_sram_rrdy_i) w_state_nxt = w_space ? S_REQ : S_IDLE;
      S_IDLE:  if (w_space) w_state_nxt = S_REQ;
      S_DRAIN: if (inst_sram_rrdy_i) w_state_nxt = S_REQ;
      S_STOP:  w_state_nxt = S_STOP;
      default: w_state_nxt = S_REQ;
    endcase
    if (redirect_i) w_state_nxt = w_inflight ? S_DRAIN : S_REQ;
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (redirect_i) begin
        r_pc     <= redirect_pc_i;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_ack) begin
          r_pc     <= r_pc + 32'd4;
          r_req_pc <= r_pc;
        end
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= w_resp_pc;
      r_mem_inst[r_wr_ptr] <= w_marker ? 32'h0 : inst_sram_rdata_i;
      r_mem_unal[r_wr_ptr] <= w_marker;
    end
  end
endmodule

// File: doc/fairy_inst_prefetch.md
# fairy_inst_prefetch

Instruction prefetch buffer between the fetch stage and the instruction SRAM port of the fairy pipeline. It issues sequential word reads using the SRAM `cen`/`ack`/`rrdy` handshake and queues returned `{pc, inst}` pairs in a small FIFO. The fetch stage drains the FIFO with a valid/pop handshake. Branch, exception and eret redirects flush the FIFO and restart fetching at the new PC, and any response still in flight is discarded.

## Interface
Parameters:
- `RESET_PC`, default 32'hbfc00000: first fetch address after reset.
- `DEPTH`, default 4: FIFO entries; power of two, minimum 2.

Ports:
- `aclk` input 1: clock; all state updates on the rising edge.
- `areset_n` input 1: reset, synchronous, active-low.
- `redirect_i` input 1: flush the buffer and restart fetching at `redirect_pc_i`.
- `redirect_pc_i` input 32: new fetch PC (branch target, exception vector or EPC).
- `pop_i` input 1: fetch stage consumes the head entry; ignored when `valid_o`=0.
- `valid_o` output 1: head entry present.
- `inst_o` output 32: head instruction; 0 when `valid_o`=0.
- `pc_o` output 32: head PC; 0 when `valid_o`=0.
- `unaligned_addr_o` output 1: head entry is an address-error marker.
- `inst_sram_cen_o` output 4: active-low byte enables; 4'b0000 = read request, 4'b1111 = idle.
- `inst_sram_wr_o` output 1: tied 0.
- `inst_sram_addr_o` output 32: request address (the fetch PC).
- `inst_sram_ack_i` input 1: request accepted this cycle.
- `inst_sram_rrdy_i` input 1: read data valid this cycle.
- `inst_sram_rdata_i` input 32: read data.

## Operation
- The fetch PC register resets to `RESET_PC`. It advances by 4 on each accepted request and loads `redirect_pc_i` on a redirect.
- At most one request is outstanding at any time.
- FSM states:
  - REQ: drive `cen`=4'b0000 and addr=PC.
    - On ack without rrdy, go to WAIT.
    - On ack with rrdy in the same cycle, push the entry, then go to REQ if space remains, otherwise IDLE.
  - WAIT: `cen`=4'b1111. On rrdy, push `{PC_of_request, rdata, 0}`, then go to REQ or IDLE.
  - IDLE: `cen`=4'b1111. Go to REQ once the post-update FIFO count is below `DEPTH`.
  - DRAIN: `cen`=4'b1111. A flushed request is in flight. On rrdy, discard the data and go to REQ.
  - STOP: `cen`=4'b1111. Entered after an unaligned marker is pushed; left only by a redirect.
- Space rule: REQ is entered only when count_next < `DEPTH`. This reserves the slot for the outstanding request.
- Unaligned PC (PC[1:0] != 0):
  - No SRAM request is issued.
  - A marker entry `{pc, 32'h0, 1}` is pushed when space is available, then the FSM enters STOP.
- Redirect priority is above push, pop, ack and rrdy:
  - The FIFO is emptied and PC is set to `redirect_pc_i`.
  - A pop in the same cycle is ignored.
  - Next state:
    - DRAIN if a request is accepted but unanswered: in WAIT without rrdy, or in REQ with ack and without rrdy.
    - REQ in all other cases.
  - In REQ without ack, the pending request is abandoned and the new address is driven the next cycle.
- Push and pop in the same cycle are both honoured; the count is unchanged.
- FIFO order is strictly PC order. Read and write pointers wrap modulo `DEPTH`.
- `rrdy` is ignored in REQ without ack, in IDLE, and in STOP.

## Timing
- Reset values while `areset_n`=0: `valid_o`=0, `inst_o`=0, `pc_o`=0, `unaligned_addr_o`=0, `inst_sram_cen_o`=4'b1111, `inst_sram_addr_o`=`RESET_PC`, `inst_sram_wr_o`=0.
- Reset clears the FIFO and the count. Reset in the middle of an operation also discards any in-flight response.
- On the first cycle after `areset_n` rises: state REQ, `cen`=4'b0000, addr=`RESET_PC`.
- SRAM outputs are combinational from registered state.
- Latency from rrdy to `valid_o` is 1 cycle (FIFO write, then registered head).
- Throughput with a zero-wait SRAM (ack and rrdy in the same cycle as the request) is one instruction per cycle.
- A redirect in cycle N produces `cen`=4'b0000 with the new address in cycle N+1, unless the FSM goes to DRAIN.

## Configuration
- `FAIRY_PREFETCH_BYPASS_EN`:
  - Defined: when the FIFO is empty, not full and not redirecting, an rrdy response also drives `valid_o`/`inst_o`/`pc_o` combinationally in the same cycle. If `pop_i` is high in that cycle, the entry is not written to the FIFO. Latency is 0 cycles.
  - Undefined: no combinational path from `inst_sram_*` inputs to outputs. Latency is always 1 cycle.

## Test plan
- Reset: hold `areset_n`=0 for 3 cycles → `cen`=4'b1111, `valid_o`=0. First cycle after release: `cen`=4'b0000, addr=32'hbfc00000.
- Zero-wait SRAM with rdata=addr and `pop_i`=0 → exactly 4 requests (bfc00000, bfc00004, bfc00008, bfc0000c), then `cen`=4'b1111. Head shows `pc_o`=bfc00000, `inst_o`=bfc00000.
- Redirect to 32'h80001000 while in WAIT, rrdy 2 cycles later with rdata=32'hdeadbeef → deadbeef never appears on the outputs. The next request addr is 80001000, and the first `valid_o` entry has `pc_o`=80001000.
- Redirect to 32'h80000002 → no SRAM request. One entry with `unaligned_addr_o`=1, `pc_o`=80000002, `inst_o`=0. `cen` stays 4'b1111 until the next redirect.
- Count=3, rrdy push coincides with `pop_i`=1 → count stays 3, pop order unchanged, and the next request is issued the following cycle.
- Empty FIFO, rrdy with rdata=32'h24020001 → `valid_o`=1 in the same cycle when `FAIRY_PREFETCH_BYPASS_EN` is defined, one cycle later when undefined.
